// File: rtl/if_id_skid_pkg.sv
// Shared definitions for the fetch/decode skid stage.
//   INST_W_DEF / ADDR_W_DEF / INT_W_DEF : default field widths
//   NOP_INST_DEF                        : bubble instruction (addi x0,x0,0)
//   INT_NONE                            : empty interrupt flag vector
//   skid_state_e                        : occupancy encoded as {M.valid, S.valid}
package if_id_skid_pkg;

    localparam int INST_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int INT_W_DEF  = 8;

    localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [INT_W_DEF-1:0]  INT_NONE     = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BAD   = 2'b01,
        ST_FULL1 = 2'b10,
        ST_FULL2 = 2'b11
    } skid_state_e;

endpackage

// File: rtl/if_id_skid_entry.sv
// pipe_entry_reg: valid bit plus payload register.
//   clk, rst : clock, synchronous active-high reset (valid=0, data=RST_VAL)
//   clear    : drop the valid bit, payload left as is (outputs mask it)
//   load     : capture data_d and mark valid
//   valid_q, data_q : registered entry
module pipe_entry_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] data_d,
    output logic         valid_q,
    output logic [W-1:0] data_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/if_id_skid.sv
// Fetch-to-decode pipeline stage with a 2-entry skid buffer.
// in_ready_o comes straight from a flop, so decode stalls never reach fetch
// combinationally.
//
// state  | meaning
// EMPTY  | nothing held, outputs show the NOP bubble
// FULL1  | M holds the beat presented to decode, S free
// FULL2  | M and S both hold beats, fetch is stalled
// BAD    | S without M; unreachable, recovers to EMPTY
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   flush_i                  : drop all held and incoming beats
//   in_valid_i / in_ready_o  : fetch handshake
//   inst_i, inst_addr_i, int_flag_i : fetch beat payload
//   out_valid_o / out_ready_i: decode handshake
//   inst_o, inst_addr_o, int_flag_o : decode payload (NOP/0/0 when invalid)
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int                INST_W   = INST_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INT_W    = INT_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [INT_W-1:0]  int_flag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [INT_W-1:0]  int_flag_o
);

    localparam int PW = INST_W + ADDR_W + INT_W;
    localparam logic [PW-1:0] PAYLOAD_RST = {NOP_INST, {ADDR_W{1'b0}}, {INT_W{1'b0}}};

    logic          m_valid, s_valid;
    logic [PW-1:0] m_data, s_data, in_data, m_data_d;
    logic          m_load, m_clear, m_from_skid;
    logic          s_load, s_clear, s_valid_next;
    logic          in_ready_q;
    logic          accept, consume;
    skid_state_e   state;

    assign in_data = {inst_i, inst_addr_i, int_flag_i};
    assign state   = skid_state_e'({m_valid, s_valid});
    assign accept  = in_valid_i & in_ready_q;
    assign consume = m_valid & out_ready_i;

    always_comb begin
        m_load      = 1'b0;
        m_clear     = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clear     = 1'b0;
        if (flush_i) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: m_load = accept;
                ST_FULL1: begin
                    if (consume && accept) m_load  = 1'b1;
                    else if (consume)      m_clear = 1'b1;
                    else if (accept)       s_load  = 1'b1;
                end
                ST_FULL2: begin
                    if (consume) begin
                        m_load      = 1'b1;
                        m_from_skid = 1'b1;
                        s_clear     = 1'b1;
                    end
                end
                ST_BAD: begin
                    m_clear = 1'b1;
                    s_clear = 1'b1;
                end
                default: ;
            endcase
        end
        m_data_d     = m_from_skid ? s_data : in_data;
        s_valid_next = s_load | (s_valid & ~s_clear);
    end

    // Ready tracks the S valid bit one-for-one, kept in its own flop.
    always_ff @(posedge clk) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= ~s_valid_next;
    end

    pipe_entry_reg #(.W(PW), .RST_VAL(PAYLOAD_RST)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (m_load),
        .clear   (m_clear),
        .data_d  (m_data_d),
        .valid_q (m_valid),
        .data_q  (m_data)
    );

    pipe_entry_reg #(.W(PW), .RST_VAL(PAYLOAD_RST)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (s_load),
        .clear   (s_clear),
        .data_d  (in_data),
        .valid_q (s_valid),
        .data_q  (s_data)
    );

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = m_valid;
    assign inst_o      = m_valid ? m_data[PW-1 -: INST_W]           : NOP_INST;
    assign inst_addr_o = m_valid ? m_data[INT_W +: ADDR_W]          : '0;
    assign int_flag_o  = m_valid ? m_data[INT_W-1:0]                : INT_W'(INT_NONE);

endmodule
